// File: rtl/cp0_pkg.sv
// ============================================================================
// Module   : cp0_pkg
// Purpose  : CP0 register indices, field positions and exception codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 10;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 10;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

endpackage

`default_nettype wire

// File: rtl/cp0_int_sync.sv
// ============================================================================
// Module   : cp0_int_sync
// Purpose  : Multi-flop synchronizer for level-sensitive external interrupts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cp0_int_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], async_in};
        end
    end

    assign sync_out = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/cp0_exception_ctrl.sv
// ============================================================================
// Module   : cp0_exception_ctrl
// Purpose  : CP0 Status/Cause/EPC, interrupt/exception arbitration, mtc0/mfc0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cp0_exception_ctrl
    import cp0_pkg::*;
#(
    parameter int N_INT    = 6,
    parameter int SYNC_STG = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic             is_cop0,
    input  logic             mtc0,
    input  logic             eret,
    input  logic [4:0]       cp0_addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [N_INT-1:0] ext_int,
    input  logic             exc_ri,
    input  logic             exc_sys,
    input  logic             exc_ov,
    output logic             hasExp,
    output logic             isEret,
    output logic [31:0]      cp0_target_addr,
    output logic [31:0]      status_q
);

    logic             r_ie;
    logic             r_exl;
    logic [N_INT-1:0] r_im;
    logic [4:0]       r_exc_code;
    logic [31:0]      r_epc;

    logic [N_INT-1:0] w_ip;
    logic             w_int_req;
    logic             w_has_exp;
    logic             w_is_eret;
    logic             w_wr;
    logic [4:0]       w_exc_code;
    logic [31:0]      w_status;
    logic [31:0]      w_cause;
    logic             w_unused_ok;

    cp0_int_sync #(
        .WIDTH  (N_INT),
        .STAGES (SYNC_STG)
    ) u_int_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ext_int),
        .sync_out (w_ip)
    );

    assign w_int_req = r_ie & ~r_exl & (|(w_ip & r_im));
    assign w_has_exp = w_int_req | exc_ri | exc_sys | exc_ov;
    assign w_is_eret = is_cop0 & eret & ~w_has_exp;
    assign w_wr      = is_cop0 & mtc0 & ~w_has_exp;

    // Fixed priority: interrupt > reserved instruction > syscall > overflow.
    always_comb begin
        w_exc_code = EXC_OV;
        if (w_int_req)    w_exc_code = EXC_INT;
        else if (exc_ri)  w_exc_code = EXC_RI;
        else if (exc_sys) w_exc_code = EXC_SYS;
    end

    always_comb begin
        w_status                                = '0;
        w_status[STATUS_IE]                     = r_ie;
        w_status[STATUS_EXL]                    = r_exl;
        w_status[STATUS_IM_LSB +: N_INT]        = r_im;
        w_cause                                 = '0;
        w_cause[CAUSE_EXC_LSB +: 5]             = r_exc_code;
        w_cause[CAUSE_IP_LSB +: N_INT]          = w_ip;
    end

    always_comb begin
        case (cp0_addr)
            CP0_STATUS: rdata = w_status;
            CP0_CAUSE:  rdata = w_cause;
            CP0_EPC:    rdata = r_epc;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ie       <= 1'b0;
            r_exl      <= 1'b0;
            r_im       <= '0;
            r_exc_code <= '0;
            r_epc      <= '0;
        end else if (w_has_exp) begin
            r_exc_code <= w_exc_code;
            r_exl      <= 1'b1;
            // A nested exception keeps the original return address.
            if (!r_exl) begin
                r_epc <= {pc[31:2], 2'b00};
            end
        end else begin
            if (w_is_eret) begin
                r_exl <= 1'b0;
            end
            if (w_wr) begin
                case (cp0_addr)
                    CP0_STATUS: begin
                        r_ie  <= wdata[STATUS_IE];
                        r_exl <= wdata[STATUS_EXL];
                        r_im  <= wdata[STATUS_IM_LSB +: N_INT];
                    end
                    CP0_EPC:  r_epc <= {wdata[31:2], 2'b00};
                    default:  ;
                endcase
            end
        end
    end

    assign hasExp          = w_has_exp;
    assign isEret          = w_is_eret;
    assign cp0_target_addr = r_epc;
    assign status_q        = w_status;
    assign w_unused_ok     = ^{pc[1:0], wdata};

endmodule

`default_nettype wire
